// File: rtl/pcie_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// pcie_tx_arb_pkg
// Shared types and helpers for the PCIe TX packet arbiter.
//   PORT_IDX_W : width of a port index for a given port count (min 1 bit)
//   BEAT_W     : packed width of one beat {last, user, keep, data}
//   arb_state_e: arbiter FSM states
// The beat struct itself is declared in the arbiter top because its field
// widths follow that module's parameters; BEAT_W gives the same width here.
// ----------------------------------------------------------------------------
package pcie_tx_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int PORT_IDX_W(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int BEAT_W(input int data_w, input int keep_w, input int user_w);
        return data_w + keep_w + user_w + 1;
    endfunction

endpackage

// File: rtl/pcie_tx_arb_skid.sv
// ----------------------------------------------------------------------------
// pcie_tx_arb_skid
// Two-entry skid buffer on a packed beat. in_ready_o depends only on the
// registered occupancy, so the upstream ready path never sees out_ready_i.
//   clk, rst                  : clock, async active-high reset (clears occupancy)
//   in_valid_i/in_ready_o     : write side handshake
//   in_data_i                 : beat to store
//   out_valid_o/out_ready_i   : read side handshake
//   out_data_o                : head entry, stable while stalled
// ----------------------------------------------------------------------------
module pcie_tx_arb_skid
    import pcie_tx_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    always_comb begin
        in_ready_o  = (count_q != 2'd2);
        out_valid_o = (count_q != 2'd0);
        out_data_o  = mem_q[rd_ptr_q];
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/pcie_tx_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// pcie_tx_pkt_arbiter
// Packet-atomic round-robin merge of NUM_PORTS AXI-S TLP streams onto one
// TX stream. A port that wins keeps the grant until its tlast beat is taken;
// priority rotates only at packet end, and a disabled port (port_en_i=0) can
// not start a new packet but always finishes the one in flight.
//   clk, rst                     : clock, async active-high reset
//   in_t{valid,data,keep,user,last}_i, in_tready_o : per-port sources
//   port_en_i                    : 1 = port may win new arbitration
//   out_t{valid,data,keep,user,last}_o, out_tready_i : merged stream
//   grant_port_o                 : current/last owner index
//   locked_o                     : a multi-beat packet is in flight
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | between packets; round-robin winner offered a slot
// ARB_LOCKED | mid-packet; only the owner may transfer until its tlast
// ----------------------------------------------------------------------------
module pcie_tx_pkt_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int DATA_W    = 512,
    parameter  int USER_W    = 10,
    parameter  int KEEP_W    = DATA_W / 8,
    localparam int IDX_W     = PORT_IDX_W(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        in_tvalid_i,
    output logic [NUM_PORTS-1:0]        in_tready_o,
    input  logic [NUM_PORTS*DATA_W-1:0] in_tdata_i,
    input  logic [NUM_PORTS*KEEP_W-1:0] in_tkeep_i,
    input  logic [NUM_PORTS*USER_W-1:0] in_tuser_i,
    input  logic [NUM_PORTS-1:0]        in_tlast_i,
    input  logic [NUM_PORTS-1:0]        port_en_i,
    output logic                        out_tvalid_o,
    input  logic                        out_tready_i,
    output logic [DATA_W-1:0]           out_tdata_o,
    output logic [KEEP_W-1:0]           out_tkeep_o,
    output logic [USER_W-1:0]           out_tuser_o,
    output logic                        out_tlast_o,
    output logic [IDX_W-1:0]            grant_port_o,
    output logic                        locked_o
);

    typedef struct packed {
        logic              last;
        logic [USER_W-1:0] user;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   grant_q, grant_d;

    logic [NUM_PORTS-1:0]   eligible;
    logic [2*NUM_PORTS-1:0] rr_dbl;
    logic [NUM_PORTS-1:0]   rr_rot;
    logic [IDX_W:0]         rr_start, rr_sum;
    logic [IDX_W-1:0]       rr_winner;
    logic                   rr_found;

    logic [IDX_W-1:0] sel;
    logic             sel_ok;
    logic             buf_ready;
    logic             push;
    beat_t            in_beat, out_beat;

    // Round-robin: rotate the request vector so last_grant+1 lands on bit 0,
    // take the lowest set bit, then rotate the index back.
    always_comb begin
        eligible = in_tvalid_i & port_en_i;
        rr_start = {1'b0, last_grant_q} + (IDX_W+1)'(1);
        rr_dbl   = {eligible, eligible} >> rr_start;
        rr_rot   = rr_dbl[NUM_PORTS-1:0];
        rr_found = |rr_rot;
        rr_sum   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rr_rot[i]) begin
                rr_sum = rr_start + (IDX_W+1)'(i);
            end
        end
        if (rr_sum >= (IDX_W+1)'(NUM_PORTS)) begin
            rr_sum = rr_sum - (IDX_W+1)'(NUM_PORTS);
        end
        rr_winner = rr_sum[IDX_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        in_tready_o  = '0;

        if (state_q == ARB_LOCKED) begin
            sel    = owner_q;
            sel_ok = 1'b1;
        end else begin
            sel    = rr_winner;
            sel_ok = rr_found;
        end

        // Ready is forced low while reset is asserted so it drops immediately.
        if (sel_ok && buf_ready && !rst) begin
            in_tready_o[sel] = 1'b1;
        end
        push = in_tready_o[sel] && in_tvalid_i[sel];

        if (push) begin
            grant_d = sel;
            if (in_tlast_i[sel]) begin
                state_d      = ARB_IDLE;
                last_grant_d = sel;
            end else begin
                state_d = ARB_LOCKED;
                owner_d = sel;
            end
        end
    end

    always_comb begin
        in_beat.data = in_tdata_i[sel*DATA_W +: DATA_W];
        in_beat.keep = in_tkeep_i[sel*KEEP_W +: KEEP_W];
        in_beat.user = in_tuser_i[sel*USER_W +: USER_W];
        in_beat.last = in_tlast_i[sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    pcie_tx_arb_skid #(
        .WIDTH (BEAT_W(DATA_W, KEEP_W, USER_W))
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (push),
        .in_ready_o  (buf_ready),
        .in_data_i   (in_beat),
        .out_valid_o (out_tvalid_o),
        .out_ready_i (out_tready_i),
        .out_data_o  (out_beat)
    );

    assign out_tdata_o  = out_beat.data;
    assign out_tkeep_o  = out_beat.keep;
    assign out_tuser_o  = out_beat.user;
    assign out_tlast_o  = out_beat.last;
    assign grant_port_o = grant_q;
    assign locked_o     = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_pcie_tx_pkt_arbiter.sv
module tb_pcie_tx_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int UW = 10;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_tvalid, in_tready, in_tlast, port_en;
    logic [N*DW-1:0] in_tdata;
    logic [N*KW-1:0] in_tkeep;
    logic [N*UW-1:0] in_tuser;
    logic            out_tvalid, out_tready, out_tlast;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic [UW-1:0]   out_tuser;
    logic [1:0]      grant_port;
    logic            locked;

    always #5 clk = ~clk;

    pcie_tx_pkt_arbiter #(
        .NUM_PORTS (N),
        .DATA_W    (DW),
        .USER_W    (UW),
        .KEEP_W    (KW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_tvalid_i  (in_tvalid),
        .in_tready_o  (in_tready),
        .in_tdata_i   (in_tdata),
        .in_tkeep_i   (in_tkeep),
        .in_tuser_i   (in_tuser),
        .in_tlast_i   (in_tlast),
        .port_en_i    (port_en),
        .out_tvalid_o (out_tvalid),
        .out_tready_i (out_tready),
        .out_tdata_o  (out_tdata),
        .out_tkeep_o  (out_tkeep),
        .out_tuser_o  (out_tuser),
        .out_tlast_o  (out_tlast),
        .grant_port_o (grant_port),
        .locked_o     (locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- sources ----------------
    int     s_len[N], s_beat[N], s_seq[N], s_npk[N], s_hold[N];
    int     s_gap_after[N], s_lmin[N], s_lmax[N], s_gap_pct[N];
    bit     s_valid[N], s_on[N];
    logic [N-1:0] acc;

    function automatic logic [DW-1:0] mk_data(input int p, input int seq, input int b);
        logic [31:0] w;
        w = {p[7:0], seq[15:0], b[7:0]};
        return {~w, w};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int p, input int b);
        logic [KW-1:0] k;
        k = '1;
        return k >> ((p + b) % KW);
    endfunction

    function automatic logic [UW-1:0] mk_user(input int p, input int seq, input int b);
        return UW'(p * 37 + seq * 3 + b);
    endfunction

    task automatic drive_src();
        for (int p = 0; p < N; p++) begin
            in_tvalid[p]           = s_valid[p];
            in_tdata[p*DW +: DW]   = mk_data(p, s_seq[p], s_beat[p]);
            in_tkeep[p*KW +: KW]   = mk_keep(p, s_beat[p]);
            in_tuser[p*UW +: UW]   = mk_user(p, s_seq[p], s_beat[p]);
            in_tlast[p]            = (s_beat[p] == s_len[p] - 1);
        end
    endtask

    task automatic src_step();
        for (int p = 0; p < N; p++) begin
            if (s_valid[p] && acc[p]) begin
                s_valid[p] = 1'b0;
                if (s_beat[p] == s_len[p] - 1) begin
                    s_beat[p] = 0;
                    s_seq[p]++;
                    if (s_npk[p] > 0) s_npk[p]--;
                end else begin
                    if (s_beat[p] == s_gap_after[p]) s_hold[p] = 2;
                    s_beat[p]++;
                end
            end
            if (!s_valid[p]) begin
                if (s_hold[p] > 0) begin
                    s_hold[p]--;
                end else if (s_beat[p] != 0) begin
                    if ($urandom_range(99) >= s_gap_pct[p]) s_valid[p] = 1'b1;
                end else if (s_on[p] && s_npk[p] != 0 && $urandom_range(99) >= s_gap_pct[p]) begin
                    s_len[p]   = $urandom_range(s_lmax[p], s_lmin[p]);
                    s_valid[p] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        src_step();
        drive_src();
    endtask

    // ---------------- behavioural model + compare ----------------
    beat_t mq[$];
    int    m_owner = -1;
    int    m_last  = N - 1;
    int    m_grant = 0;
    int    m_log[$];
    bit    lk_log[$];
    int    cyc = 0;
    int    first_push_cyc = -1, first_ov_cyc = -1, ov_gaps = 0, stall0 = 0;

    int           c_sel, c_p;
    logic [N-1:0] c_rdy;
    bit           c_push, c_pop;
    beat_t        c_nb;

    always begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            m_owner = -1;
            m_last  = N - 1;
            m_grant = 0;
            acc     = '0;
            check("rst_in_tready", in_tready, 0);
            check("rst_out_tvalid", out_tvalid, 0);
            check("rst_locked", locked, 0);
            check("rst_grant", grant_port, 0);
        end else begin
            c_sel = -1;
            if (m_owner >= 0) begin
                c_sel = m_owner;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    c_p = (m_last + k) % N;
                    if (c_sel < 0 && in_tvalid[c_p] && port_en[c_p]) c_sel = c_p;
                end
            end
            c_rdy = '0;
            if (c_sel >= 0 && mq.size() < 2) c_rdy[c_sel] = 1'b1;

            check("in_tready", in_tready, c_rdy);
            check("out_tvalid", out_tvalid, mq.size() > 0);
            if (mq.size() > 0)
                check("out_beat", {out_tlast, out_tuser, out_tkeep, out_tdata}, mq[0]);
            check("grant_port", grant_port, m_grant);
            check("locked", locked, m_owner >= 0);

            acc = in_tvalid & in_tready;
            if (in_tvalid[0] && !in_tready[0]) stall0++;
            if (first_ov_cyc < 0 && out_tvalid) first_ov_cyc = cyc;
            else if (first_ov_cyc >= 0 && !out_tvalid) ov_gaps++;

            c_push = (c_sel >= 0) && c_rdy[c_sel] && in_tvalid[c_sel];
            c_pop  = (mq.size() > 0) && out_tready;
            if (c_push) begin
                c_nb.last = in_tlast[c_sel];
                c_nb.user = in_tuser[c_sel*UW +: UW];
                c_nb.keep = in_tkeep[c_sel*KW +: KW];
                c_nb.data = in_tdata[c_sel*DW +: DW];
                m_log.push_back(c_sel);
                if (c_sel == 1) lk_log.push_back(locked);
                if (first_push_cyc < 0) first_push_cyc = cyc;
            end
            @(posedge clk);
            if (!rst) begin
                if (c_pop) void'(mq.pop_front());
                if (c_push) begin
                    mq.push_back(c_nb);
                    m_grant = c_sel;
                    if (c_nb.last) begin
                        m_owner = -1;
                        m_last  = c_sel;
                    end else begin
                        m_owner = c_sel;
                    end
                end
            end
        end
    end

    // ---------------- phases ----------------
    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            s_valid[p] = 1'b0; s_beat[p] = 0; s_seq[p] = 0; s_hold[p] = 0;
            s_on[p] = 1'b0; s_npk[p] = -1; s_gap_after[p] = -1; s_gap_pct[p] = 0;
            s_lmin[p] = 1; s_lmax[p] = 1; s_len[p] = 1;
        end
        drive_src();
        port_en    = '1;
        out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_log.delete();
        lk_log.delete();
        stall0 = 0; ov_gaps = 0; first_push_cyc = -1; first_ov_cyc = -1;
    endtask

    function automatic int count_port(input int p);
        int c = 0;
        foreach (m_log[i]) if (m_log[i] == p) c++;
        return c;
    endfunction

    int  a_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int  b_exp[5] = '{1, 1, 1, 1, 2};
    bit  b_lk[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    int  c_pat[8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    int  f_exp[4] = '{3, 3, 3, 1};
    bit  found;

    initial begin
        in_tvalid = '0; in_tlast = '0; in_tdata = '0; in_tkeep = '0; in_tuser = '0;
        port_en = '1; out_tready = 1'b1; acc = '0;
        #7;
        check("init_in_tready", in_tready, 0);
        check("init_out_tvalid", out_tvalid, 0);
        check("init_locked", locked, 0);
        check("init_grant", grant_port, 0);

        // A: every port offers back-to-back single-beat packets
        do_reset();
        for (int p = 0; p < N; p++) s_on[p] = 1'b1;
        repeat (20) tick();
        check("A_len", m_log.size() >= 8, 1);
        if (m_log.size() >= 8)
            for (int i = 0; i < 8; i++) check("A_order", m_log[i], a_exp[i]);
        check("A_latency", first_ov_cyc - first_push_cyc, 1);
        check("A_throughput_gaps", ov_gaps, 0);

        // B: 4-beat packet on port 1 while port 2 has singles pending
        do_reset();
        s_on[1] = 1'b1; s_npk[1] = 1; s_lmin[1] = 4; s_lmax[1] = 4;
        s_on[2] = 1'b1;
        repeat (15) tick();
        check("B_len", m_log.size() >= 5, 1);
        if (m_log.size() >= 5)
            for (int i = 0; i < 5; i++) check("B_order", m_log[i], b_exp[i]);
        check("B_lklen", lk_log.size(), 4);
        if (lk_log.size() == 4)
            for (int i = 0; i < 4; i++) check("B_locked", lk_log[i], b_lk[i]);

        // C: out_tready 1,0,0,1 while port 0 sends two 3-beat packets
        do_reset();
        s_on[0] = 1'b1; s_npk[0] = 2; s_lmin[0] = 3; s_lmax[0] = 3;
        for (int i = 0; i < 20; i++) begin
            tick();
            out_tready = (i < 8) ? c_pat[i][0] : 1'b1;
        end
        check("C_beats", count_port(0), 6);
        check("C_stall_cycles", stall0, 2);

        // D: port_en[0] dropped after beat 0 of a 3-beat packet
        do_reset();
        s_on[0] = 1'b1; s_lmin[0] = 3; s_lmax[0] = 3;
        s_on[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (s_beat[0] >= 1) begin
                port_en[0] = 1'b0;
                found = 1'b1;
            end
        end
        check("D_wait", found, 1);
        repeat (15) tick();
        check("D_port0_beats", count_port(0), 3);
        check("D_len", m_log.size() >= 4, 1);
        if (m_log.size() >= 4) check("D_next_port3", m_log[3], 3);

        // E: reset asserted on beat 2 of a 5-beat packet
        do_reset();
        for (int p = 0; p < N; p++) begin
            s_on[p] = 1'b1; s_lmin[p] = 5; s_lmax[p] = 5;
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (s_beat[0] == 2) found = 1'b1;
        end
        check("E_wait", found, 1);
        #2;
        rst = 1'b1;
        #1;
        check("E_async_tready", in_tready, 0);
        check("E_async_tvalid", out_tvalid, 0);
        check("E_async_locked", locked, 0);
        do_reset();
        for (int p = 0; p < N; p++) s_on[p] = 1'b1;
        repeat (8) tick();
        check("E_len", m_log.size() >= 2, 1);
        if (m_log.size() >= 2) begin
            check("E_first_grant", m_log[0], 0);
            check("E_second_grant", m_log[1], 1);
        end

        // F: port 3 alone with a 2-cycle gap mid-packet; port 1 wakes in the gap
        do_reset();
        s_on[3] = 1'b1; s_npk[3] = 1; s_lmin[3] = 3; s_lmax[3] = 3; s_gap_after[3] = 0;
        found = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!found && s_beat[3] == 1) begin
                s_on[1] = 1'b1; s_npk[1] = 1;
                found = 1'b1;
            end
        end
        check("F_wait", found, 1);
        check("F_len", m_log.size(), 4);
        if (m_log.size() == 4)
            for (int i = 0; i < 4; i++) check("F_order", m_log[i], f_exp[i]);

        // R: random traffic, gaps, back-pressure and enable toggles
        do_reset();
        for (int p = 0; p < N; p++) begin
            s_on[p] = 1'b1; s_lmin[p] = 1; s_lmax[p] = 6; s_gap_pct[p] = 25;
        end
        for (int i = 0; i < 3000; i++) begin
            tick();
            out_tready = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) port_en[$urandom_range(N-1)] ^= 1'b1;
        end
        check("R_traffic", m_log.size() > 500, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
